// File: rtl/system_led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: FSM states, register map
// and CTRL/STATUS bit positions.
package system_led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } led_state_e;

  localparam logic [3:0] ADDR_CTRL         = 4'd0;
  localparam logic [3:0] ADDR_STATUS       = 4'd1;
  localparam logic [3:0] ADDR_PERIOD       = 4'd2;
  localparam logic [3:0] ADDR_LENGTH       = 4'd3;
  localparam logic [3:0] ADDR_PATTERN_BASE = 4'd8;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_LOOP_BIT    = 1;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_DONE_BIT  = 1;
  localparam int STATUS_INDEX_LSB = 4;

  localparam int IDX_W = 4;
  localparam int LEN_W = 5;

  // Number of table entries a run actually walks through.
  function automatic logic [LEN_W-1:0] effective_length(input logic [LEN_W-1:0] length,
                                                        input int depth);
    logic [LEN_W-1:0] depth_l;
    depth_l = LEN_W'(depth);
    return (length > depth_l) ? depth_l : length;
  endfunction

endpackage

// File: rtl/system_led_seq_timer.sv
// Loadable down-counter that paces the HOLD phase; saturates at zero.
module system_led_seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/system_led_sequencer.sv
// Register-programmed LED pattern sequencer: steps through a pattern table and
// writes each entry to an LED PIO at a programmable period.
module system_led_sequencer
  import system_led_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  led_state_e state_q, state_d;

  logic             enable_q, loop_q, done_q;
  logic [CNT_W-1:0] period_q;
  logic [LEN_W-1:0] length_q;
  logic [IDX_W-1:0] index_q;
  logic [7:0]       pattern_q [DEPTH];

  logic             wr_en, ctrl_wr, status_wr, period_wr, length_wr;
  logic [IDX_W-1:0] pat_off;
  logic             pat_hit;
  logic [7:0]       rd_pattern, cur_pattern;
  logic [LEN_W-1:0] eff_len;
  logic             last_entry, enable_eff;
  logic [CNT_W-1:0] period_eff, timer_load_value;
  logic             timer_load, timer_en, timer_zero;
  logic             start_run, finish_run, idx_advance, idx_wrap;

  // Slave decode
  assign wr_en     = s_chipselect && !s_write_n;
  assign ctrl_wr   = wr_en && (s_address == ADDR_CTRL);
  assign status_wr = wr_en && (s_address == ADDR_STATUS);
  assign period_wr = wr_en && (s_address == ADDR_PERIOD);
  assign length_wr = wr_en && (s_address == ADDR_LENGTH);
  assign pat_off   = s_address - ADDR_PATTERN_BASE;

  // A CTRL write landing this cycle overrides the stored enable, so a software
  // stop takes effect before another LED write can be issued.
  assign enable_eff = ctrl_wr ? s_writedata[CTRL_ENABLE_BIT] : enable_q;

  assign eff_len    = effective_length(length_q, DEPTH);
  assign last_entry = (eff_len == '0) || ((LEN_W'(index_q) + LEN_W'(1)) >= eff_len);

  assign period_eff       = (period_q < CNT_W'(2)) ? CNT_W'(2) : period_q;
  assign timer_load_value = period_eff - CNT_W'(2);

  always_comb begin
    rd_pattern  = '0;
    cur_pattern = '0;
    pat_hit     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (s_address >= ADDR_PATTERN_BASE && pat_off == IDX_W'(i)) begin
        pat_hit    = 1'b1;
        rd_pattern = pattern_q[i];
      end
      if (index_q == IDX_W'(i)) cur_pattern = pattern_q[i];
    end
  end

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    start_run    = 1'b0;
    finish_run   = 1'b0;
    idx_advance  = 1'b0;
    idx_wrap     = 1'b0;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = '0;
    case (state_q)
      IDLE: begin
        if (enable_q) begin
          if (eff_len != '0) begin
            start_run = 1'b1;
            state_d   = WRITE;
          end else begin
            finish_run = 1'b1;
          end
        end
      end
      WRITE: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_writedata  = {24'b0, cur_pattern};
        timer_load   = 1'b1;
        state_d      = enable_eff ? HOLD : IDLE;
      end
      HOLD: begin
        timer_en = 1'b1;
        if (!enable_eff) begin
          state_d = IDLE;
        end else if (timer_zero) begin
          if (!last_entry) begin
            idx_advance = 1'b1;
            state_d     = WRITE;
          end else if (loop_q) begin
            idx_wrap = 1'b1;
            state_d  = WRITE;
          end else begin
            finish_run = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      loop_q   <= 1'b0;
      done_q   <= 1'b0;
      period_q <= '0;
      length_q <= '0;
      index_q  <= '0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= s_writedata[CTRL_ENABLE_BIT];
        loop_q   <= s_writedata[CTRL_LOOP_BIT];
      end else if (finish_run) begin
        enable_q <= 1'b0;
      end
      if (period_wr) period_q <= CNT_W'(s_writedata);
      if (length_wr) length_q <= s_writedata[LEN_W-1:0];
      // A completion in the same cycle as a W1C keeps done set.
      if (finish_run) begin
        done_q <= 1'b1;
      end else if (start_run || (status_wr && s_writedata[STATUS_DONE_BIT])) begin
        done_q <= 1'b0;
      end
      if (start_run || idx_wrap) begin
        index_q <= '0;
      end else if (idx_advance) begin
        index_q <= index_q + IDX_W'(1);
      end
    end
  end

  // NOTE: the pattern table is small and software expects it to read back as
  // zero after reset, so it is built from resettable flops rather than RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pattern_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && pat_hit && pat_off == IDX_W'(i)) pattern_q[i] <= s_writedata[7:0];
      end
    end
  end

  system_led_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_load_value),
    .enable     (timer_en),
    .zero       (timer_zero)
  );

  always_comb begin
    s_readdata = '0;
    case (s_address)
      ADDR_CTRL: begin
        s_readdata[CTRL_ENABLE_BIT] = enable_q;
        s_readdata[CTRL_LOOP_BIT]   = loop_q;
      end
      ADDR_STATUS: begin
        s_readdata[STATUS_BUSY_BIT]                 = (state_q != IDLE);
        s_readdata[STATUS_DONE_BIT]                 = done_q;
        s_readdata[STATUS_INDEX_LSB +: IDX_W]       = index_q;
      end
      ADDR_PERIOD: s_readdata = 32'(period_q);
      ADDR_LENGTH: s_readdata[LEN_W-1:0] = length_q;
      default:     if (pat_hit) s_readdata[7:0] = rd_pattern;
    endcase
  end

  assign m_address = 2'b00;

endmodule

// File: tb/tb_system_led_sequencer.sv
// Directed bench for system_led_sequencer: expected LED writes are queued with
// their spacing and matched by a monitor as the DUT issues them.
module tb_system_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   last_wr_cyc = 0;

  system_led_sequencer #(.DEPTH(8), .CNT_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Monitor: sample master side on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) check("m_cs_in_reset", 32'(m_chipselect), 32'd0);
    if (m_chipselect) begin
      check("m_write_n_active", 32'(m_write_n), 32'd0);
      check("m_address", 32'(m_address), 32'd0);
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("led_data", m_writedata, {24'b0, e.data});
        if (e.gap != 0) check("led_gap", 32'(cyc - last_wr_cyc), 32'(e.gap));
      end
      last_wr_cyc = cyc;
    end else begin
      check("m_idle_write_n", 32'(m_write_n), 32'd1);
      check("m_idle_writedata", m_writedata, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    s_address    = a;
    s_writedata  = d;
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    s_address    = a;
    s_chipselect = 1'b1;
    s_write_n    = 1'b1;
    #1;
    d            = s_readdata;
    s_chipselect = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic expect_write(input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic wait_sb_size(input string tag, input int target, input int budget);
    int k = 0;
    while (sb.size() != target && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(sb.size()), 32'(target));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (dut.s_readdata !== 32'hX && k < budget) begin
      s_address = 4'd1;
      #1;
      if (s_readdata[0] == 1'b0) break;
      step(1);
      k++;
    end
    s_address = 4'd1;
    #1;
    check(tag, 32'(s_readdata[0]), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    s_address    = '0;
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
    s_writedata  = '0;
    step(3);

    // Reset state
    check_reg("rst_ctrl", 4'd0, 32'h0);
    check_reg("rst_status", 4'd1, 32'h0);
    check_reg("rst_period", 4'd2, 32'h0);
    reset_n = 1'b1;
    step(2);
    check_reg("rst_length", 4'd3, 32'h0);
    check_reg("rst_pattern7", 4'd15, 32'h0);

    // Unmapped address ignores writes and reads 0
    bus_write(4'd4, 32'hFFFF_FFFF);
    check_reg("unmapped_read", 4'd4, 32'h0);

    // Single pass: 3 entries, period 5
    bus_write(4'd8,  32'hFFFF_FF01);
    bus_write(4'd9,  32'h02);
    bus_write(4'd10, 32'h04);
    check_reg("pattern0_bits", 4'd8, 32'h01);
    bus_write(4'd2, 32'd5);
    bus_write(4'd3, 32'd3);
    check_reg("period_rb", 4'd2, 32'd5);
    expect_write(8'h01, 0);
    expect_write(8'h02, 5);
    expect_write(8'h04, 5);
    bus_write(4'd0, 32'h1);
    wait_sb_size("single_drained", 0, 200);
    wait_idle("single_idle", 50);
    check_reg("single_status", 4'd1, 32'h22);
    check_reg("single_ctrl", 4'd0, 32'h0);

    // W1C on done leaves the index field alone
    bus_write(4'd1, 32'h2);
    check_reg("w1c_status", 4'd1, 32'h20);

    // Loop mode, then software stop during HOLD
    expect_write(8'h01, 0);
    expect_write(8'h02, 5);
    expect_write(8'h04, 5);
    expect_write(8'h01, 5);
    bus_write(4'd0, 32'h3);
    check_reg("loop_ctrl", 4'd0, 32'h3);
    wait_sb_size("loop_drained", 0, 200);
    bus_write(4'd0, 32'h0);
    check_reg("stop_status", 4'd1, 32'h00);
    step(12);
    check_reg("stop_ctrl", 4'd0, 32'h0);

    // Minimum period: PERIOD=0 behaves as 2
    bus_write(4'd2, 32'd0);
    bus_write(4'd3, 32'd2);
    expect_write(8'h01, 0);
    expect_write(8'h02, 2);
    bus_write(4'd0, 32'h1);
    wait_sb_size("p0_drained", 0, 200);
    wait_idle("p0_idle", 50);
    check_reg("p0_status", 4'd1, 32'h12);

    // LENGTH beyond DEPTH is clamped to 8 entries
    for (int i = 3; i < 8; i++) bus_write(4'(8 + i), 32'(8'h01 << i));
    bus_write(4'd3, 32'd20);
    check_reg("len20_rb", 4'd3, 32'd20);
    for (int i = 0; i < 8; i++) expect_write(8'h01 << i, (i == 0) ? 0 : 2);
    bus_write(4'd0, 32'h1);
    wait_sb_size("len20_drained", 0, 300);
    wait_idle("len20_idle", 50);
    check_reg("len20_status", 4'd1, 32'h72);

    // Zero length: done without any write
    bus_write(4'd1, 32'h2);
    check_reg("len0_pre_status", 4'd1, 32'h70);
    bus_write(4'd3, 32'd0);
    bus_write(4'd0, 32'h1);
    step(4);
    s_address = 4'd1;
    #1;
    check("len0_status_bits", s_readdata & 32'h3, 32'h2);
    check_reg("len0_ctrl", 4'd0, 32'h0);

    // Pattern update while index 0 is holding; enable rewrite while busy
    bus_write(4'd2, 32'd5);
    bus_write(4'd3, 32'd3);
    bus_write(4'd9, 32'h02);
    expect_write(8'h01, 0);
    expect_write(8'hAA, 5);
    expect_write(8'h04, 5);
    bus_write(4'd0, 32'h1);
    wait_sb_size("upd_first", 2, 100);
    check_reg("upd_hold_status", 4'd1, 32'h01);
    bus_write(4'd9, 32'hAA);
    bus_write(4'd0, 32'h1);
    wait_sb_size("upd_drained", 0, 200);
    wait_idle("upd_idle", 50);
    check_reg("upd_status", 4'd1, 32'h22);

    // Reset during HOLD aborts the run
    expect_write(8'h01, 0);
    bus_write(4'd0, 32'h3);
    wait_sb_size("rst_run_first", 0, 100);
    reset_n = 1'b0;
    step(3);
    check_reg("in_rst_status", 4'd1, 32'h0);
    check_reg("in_rst_ctrl", 4'd0, 32'h0);
    reset_n = 1'b1;
    step(15);
    check_reg("post_rst_ctrl", 4'd0, 32'h0);
    check_reg("post_rst_status", 4'd1, 32'h0);
    check_reg("post_rst_period", 4'd2, 32'h0);
    check_reg("post_rst_length", 4'd3, 32'h0);
    check_reg("post_rst_pattern0", 4'd8, 32'h0);
    check_reg("post_rst_pattern1", 4'd9, 32'h0);
    check("post_rst_sb", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
